counter_seq_ctrl: RTL

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_ctrl_pkg.sv | 23 ++
 rtl/counter8_dp.sv | 42 ++++
 rtl/counter_seq_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer: FSM states, command codes
// and default widths.
package counter_ctrl_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DIV_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_START  = 2'b00,
        OP_STOP   = 2'b01,
        OP_PAUSE  = 2'b10,
        OP_RESUME = 2'b11
    } op_t;

endpackage

// File: rtl/counter8_dp.sv
// Counter datapath: parallel load or +/-1 step, wrapping modulo 2^WIDTH.
// The next value is exposed so the controller can detect a terminal write
// in the same cycle it happens.
module counter8_dp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] ld_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] count_nxt_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over a step; otherwise count up or down with natural wrap.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = ld_val_i;
        end else if (en_i) begin
            count_d = dir_i ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign count_nxt_o = count_d;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven counter sequencer: START/STOP/PAUSE/RESUME control, a
// prescaler that gates count steps, one-shot or periodic operation and a
// one-cycle terminal-count strobe aligned with count==term.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cfg_load,
    input  logic [WIDTH-1:0] cfg_term,
    input  logic             cfg_dir,
    input  logic             cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] psc_q, psc_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tc_q, tc_d;

    logic             accept;
    logic             step;
    logic             reload;
    logic             dp_load;
    logic             dp_en;
    logic             hit;
    logic [WIDTH-1:0] count_nxt;

    counter8_dp #(.WIDTH(WIDTH)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dp_load),
        .en_i       (dp_en),
        .dir_i      (dir_q),
        .ld_val_i   (load_q),
        .count_o    (count),
        .count_nxt_o(count_nxt)
    );

    // Any accepted command suppresses the step of that cycle, so a STOP or
    // restart landing on a step edge never moves count or fires tc_pulse.
    assign cmd_ready = (state_q != ST_LOAD);
    assign accept    = cmd_valid && cmd_ready;
    assign step      = (state_q == ST_RUN) && (psc_q == div_q) && !accept;
    assign reload    = step && mode_q && (count == term_q);
    assign dp_load   = (state_q == ST_LOAD) || reload;
    assign dp_en     = step && !reload;
    assign hit       = (dp_load || dp_en) && (count_nxt == term_q);

    // Next-state, prescaler and shadow-register logic; commands override.
    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        load_d  = load_q;
        term_d  = term_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        div_d   = div_q;
        tc_d    = hit;

        case (state_q)
            ST_LOAD: begin
                psc_d   = '0;
                state_d = (hit && !mode_q) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (!accept) begin
                    psc_d = (psc_q == div_q) ? '0 : (psc_q + DIV_W'(1));
                end
                if (hit && !mode_q) begin
                    state_d = ST_DONE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            case (op_t'(cmd_op))
                OP_START: begin
                    load_d  = cfg_load;
                    term_d  = cfg_term;
                    dir_d   = cfg_dir;
                    mode_d  = cfg_mode;
                    div_d   = cfg_div;
                    state_d = ST_LOAD;
                end
                OP_STOP:   state_d = ST_IDLE;
                OP_PAUSE:  if (state_q == ST_RUN)   state_d = ST_PAUSE;
                OP_RESUME: if (state_q == ST_PAUSE) state_d = ST_RUN;
                default: ;
            endcase
        end
    end

    // Control and shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            psc_q   <= '0;
            load_q  <= '0;
            term_q  <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            div_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            load_q  <= load_d;
            term_q  <= term_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            tc_q    <= tc_d;
        end
    end

    assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done     = (state_q == ST_DONE);
    assign tc_pulse = tc_q;

endmodule
